// File: rtl/hdmi_i2c_target.sv
`default_nettype none
// ============================================================================
// hdmi_i2c_target : I2C target with a register file mimicking the HDMI TX map
// Revision: 1.0 - initial release
// ============================================================================
module hdmi_i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         AW          = 8,
  parameter logic [7:0] STATUS_ADDR = 8'h42
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [7:0]    status_in,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  localparam int            DEPTH      = 2**AW;
  localparam logic [AW-1:0] STATUS_IDX = AW'(STATUS_ADDR);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8
  } state_t;

  state_t        state;
  logic          scl_meta, scl_sync, scl_hist;
  logic          sda_meta, sda_sync, sda_hist;
  logic [7:0]    shreg;
  logic [3:0]    bitcnt;
  logic [AW-1:0] ptr;
  logic          rw;
  logic          commit;
  logic [7:0]    regfile [DEPTH];

  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [AW-1:0] ptr_inc;
  logic [7:0]    cur_byte, nxt_byte;

  assign scl_rise  =  scl_sync & ~scl_hist;
  assign scl_fall  = ~scl_sync &  scl_hist;
  assign start_det =  scl_sync &  scl_hist &  sda_hist & ~sda_sync;
  assign stop_det  =  scl_sync &  scl_hist & ~sda_hist &  sda_sync;
  assign ptr_inc   = ptr + 1'b1;
  assign cur_byte  = (ptr == STATUS_IDX)     ? status_in : regfile[ptr];
  assign nxt_byte  = (ptr_inc == STATUS_IDX) ? status_in : regfile[ptr_inc];

  // Synchronisers reset to the idle-bus level so reset alone never fakes a START.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      scl_meta <= 1'b1; scl_sync <= 1'b1; scl_hist <= 1'b1;
      sda_meta <= 1'b1; sda_sync <= 1'b1; sda_hist <= 1'b1;
    end else begin
      scl_meta <= scl_in;   scl_sync <= scl_meta; scl_hist <= scl_sync;
      sda_meta <= sda_in;   sda_sync <= sda_meta; sda_hist <= sda_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      shreg   <= '0;
      bitcnt  <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      commit  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      // A completed write byte is committed the cycle after its 8th sample.
      if (commit) begin
        commit <= 1'b0;
        if (ptr != STATUS_IDX) begin
          regfile[ptr] <= shreg;
          wr_stb       <= 1'b1;
          wr_addr      <= ptr;
          wr_data      <= shreg;
        end
        ptr <= ptr_inc;
      end
      if (start_det) begin
        state  <= ADDR;
        bitcnt <= '0;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, REG, WDATA: begin
            if (scl_rise && bitcnt != 4'd8) begin
              shreg  <= {shreg[6:0], sda_sync};
              bitcnt <= bitcnt + 4'd1;
              if (state == WDATA && bitcnt == 4'd7) commit <= 1'b1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              bitcnt <= '0;
              if (state == ADDR) begin
                if (shreg[7:1] == DEV_ADDR) begin
                  sda_oe <= 1'b1;
                  rw     <= shreg[0];
                  busy   <= 1'b1;
                  state  <= ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end else if (state == REG) begin
                ptr    <= AW'(shreg);
                sda_oe <= 1'b1;
                state  <= REG_ACK;
              end else begin
                sda_oe <= 1'b1;
                state  <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (rw) begin
              // The ACK release and the first read bit share this SCL fall.
              shreg  <= {cur_byte[6:0], 1'b0};
              sda_oe <= ~cur_byte[7];
              bitcnt <= 4'd1;
              state  <= RDATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= REG;
            end
          end
          REG_ACK, WDATA_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= WDATA;
          end
          RDATA: if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              sda_oe <= 1'b0;
              bitcnt <= '0;
              state  <= RDATA_ACK;
            end else begin
              sda_oe <= ~shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
              bitcnt <= bitcnt + 4'd1;
            end
          end
          RDATA_ACK: if (scl_rise) begin
            ptr <= ptr_inc;
            if (!sda_sync) begin
              shreg <= nxt_byte;
              state <= RDATA;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
